tmr_vote_ctrl: RTL and testbench

// - Sequencing controller for triple-modular-redundant (TMR) voting.
// - Captures three redundant channel words under a valid/ready handshake and produces a bitwise 2-of-3 vote.
// - Tracks consecutive per-channel disagreement and latches a sticky fault once a channel reaches FAULT_THRESH.
// - Masks faulted channels out of later votes; sits between the redundant sources and the downstream consumer.

---
 rtl/tmr_vote_ctrl_pkg.sv | 34 +++
 rtl/tmr_fault_cnt.sv | 36 +++
 rtl/tmr_vote_ctrl.sv | 113 +++++++++++
 tb/tb_tmr_vote_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_vote_ctrl_pkg.sv
// Shared types and helpers for the TMR voting controller.
// The per-bit vote function encodes the masked 2-of-3 rules for one bit column.
package tmr_vote_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_OUT     = 2'd2
   } state_t;

   localparam int NUM_CH = 3;
   localparam int CH1    = 0;
   localparam int CH2    = 1;
   localparam int CH3    = 2;

   // Returns {err, value} for one bit column; h flags the healthy channels.
   // With two healthy channels the lower-index one wins a disagreement.
   function automatic logic [1:0] vote_bit(input logic [2:0] b, input logic [2:0] h);
      logic [1:0] r;
      r = {1'b1, b[CH1]};
      case (h)
         3'b111: r = {1'b0, (b[CH1] & b[CH2]) | (b[CH1] & b[CH3]) | (b[CH2] & b[CH3])};
         3'b011: r = {b[CH1] ^ b[CH2], b[CH1]};
         3'b101: r = {b[CH1] ^ b[CH3], b[CH1]};
         3'b110: r = {b[CH2] ^ b[CH3], b[CH2]};
         3'b001: r = {1'b1, b[CH1]};
         3'b010: r = {1'b1, b[CH2]};
         3'b100: r = {1'b1, b[CH3]};
         default: r = {1'b1, b[CH1]};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tmr_fault_cnt.sv
// Per-channel consecutive-mismatch counter with a sticky fault flag.
// Counter and flag freeze once the fault latches; clr wins over any update.
module tmr_fault_cnt #(
   parameter int THRESH = 3,
   parameter int CW     = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mismatch,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          fault
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         fault <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         fault <= 1'b0;
      end else if (en && !fault) begin
         if (mismatch) begin
            if (cnt < CW'(THRESH))
               cnt <= cnt + 1'b1;
            // Latch on the same edge the count reaches the threshold.
            if (cnt == CW'(THRESH - 1))
               fault <= 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/tmr_vote_ctrl.sv
// TMR voting controller: captures three channel words, votes bitwise with
// faulted channels masked out, and tracks per-channel disagreement.
module tmr_vote_ctrl
   import tmr_vote_ctrl_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int FAULT_THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ch1,
   input  logic [WIDTH-1:0] ch2,
   input  logic [WIDTH-1:0] ch3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] vote,
   output logic             out_err,
   output logic [2:0]       disagree,
   output logic [2:0]       fault,
   input  logic             clr_fault
);

   localparam int CW = $clog2(FAULT_THRESH + 1);

   state_t                           state, state_nx;
   logic [NUM_CH-1:0][WIDTH-1:0]     cap;
   logic [NUM_CH-1:0][CW-1:0]        cnt;
   logic [WIDTH-1:0]                 vote_nx;
   logic [WIDTH-1:0]                 err_bits;
   logic [NUM_CH-1:0]                mismatch;
   logic [NUM_CH-1:0]                disagree_nx;
   logic [1:0]                       vb;
   logic                             en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_CAPTURE;
         end
         S_CAPTURE: state_nx = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign en = (state == S_CAPTURE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cap <= '0;
      else if (state == S_IDLE && in_valid) cap <= {ch3, ch2, ch1};
   end

   // Vote against the fault mask as it stands before this result's update.
   always_comb begin
      vote_nx  = '0;
      err_bits = '0;
      vb       = '0;
      for (int b = 0; b < WIDTH; b++) begin
         vb          = vote_bit({cap[CH3][b], cap[CH2][b], cap[CH1][b]}, ~fault);
         vote_nx[b]  = vb[0];
         err_bits[b] = vb[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote     <= '0;
         out_err  <= 1'b0;
         disagree <= '0;
      end else if (en) begin
         vote     <= vote_nx;
         out_err  <= |err_bits;
         disagree <= disagree_nx;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign mismatch[i]    = (cap[i] != vote_nx);
      assign disagree_nx[i] = mismatch[i] & ~fault[i];

      tmr_fault_cnt #(
         .THRESH (FAULT_THRESH),
         .CW     (CW)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .mismatch (mismatch[i]),
         .clr      (clr_fault),
         .cnt      (cnt[i]),
         .fault    (fault[i])
      );

      // A latched fault always sits on a saturated counter, and only there.
      a_cnt_fault: assert property (@(posedge clk) disable iff (rst)
         fault[i] == (cnt[i] == CW'(FAULT_THRESH)));
   end

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed bench for tmr_vote_ctrl: a vector table of words with hand-computed
// results, followed by reset, backpressure and clear-race sequences.
module tb_tmr_vote_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] ch1 = '0, ch2 = '0, ch3 = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] vote;
   logic       out_err;
   logic [2:0] disagree;
   logic [2:0] fault;
   logic       clr_fault = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   tmr_vote_ctrl #(.WIDTH(4), .FAULT_THRESH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ch1       (ch1),
      .ch2       (ch2),
      .ch3       (ch3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .vote      (vote),
      .out_err   (out_err),
      .disagree  (disagree),
      .fault     (fault),
      .clr_fault (clr_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pre_clr;
      logic [3:0] c1, c2, c3;
      logic [3:0] ev;
      logic       ee;
      logic [2:0] ed, ef;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer a word and accept it; returns after the accepting edge (+1).
   task automatic accept_word(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      int k;
      @(negedge clk);
      in_valid = 1'b1;
      ch1 = a; ch2 = b; ch3 = c;
      k = 0;
      while (!in_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ch1 = 4'($urandom); ch2 = 4'($urandom); ch3 = 4'($urandom);
   endtask

   // Full transaction: accept, wait for the result with a bound, then compare.
   task automatic run_word(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] ev, input logic ee,
                           input logic [2:0] ed, input logic [2:0] ef, input string tag);
      int n;
      accept_word(a, b, c);
      chk({tag, "_busy"}, 32'({in_ready, out_valid}), 32'b00);
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd1);
      chk({tag, "_vote"}, 32'(vote), 32'(ev));
      chk({tag, "_err"}, 32'(out_err), 32'(ee));
      chk({tag, "_disagree"}, 32'(disagree), 32'(ed));
      chk({tag, "_fault"}, 32'(fault), 32'(ef));
   endtask

   initial begin
      //          clr  c1     c2     c3     vote   err   dis     fault
      vecs[0]  = '{1'b0, 4'h5, 4'h5, 4'h5, 4'h5, 1'b0, 3'b000, 3'b000};
      vecs[1]  = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000};
      vecs[2]  = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000};
      vecs[3]  = '{1'b0, 4'h3, 4'h3, 4'h3, 4'h3, 1'b0, 3'b000, 3'b000};
      vecs[4]  = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000};
      vecs[5]  = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000};
      vecs[6]  = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b001};
      vecs[7]  = '{1'b0, 4'h0, 4'hA, 4'hA, 4'hA, 1'b0, 3'b000, 3'b001};
      vecs[8]  = '{1'b0, 4'h0, 4'h1, 4'h2, 4'h1, 1'b1, 3'b100, 3'b001};
      vecs[9]  = '{1'b0, 4'h0, 4'h7, 4'h7, 4'h7, 1'b0, 3'b000, 3'b001};
      vecs[10] = '{1'b1, 4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 3'b111, 3'b000};
      vecs[11] = '{1'b0, 4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 3'b111, 3'b000};
      vecs[12] = '{1'b0, 4'h1, 4'h2, 4'h4, 4'h0, 1'b0, 3'b111, 3'b111};
      vecs[13] = '{1'b0, 4'h6, 4'h9, 4'hC, 4'h6, 1'b1, 3'b000, 3'b111};

      // Power-on reset
      #12;
      chk("rst_hold", 32'({in_ready, out_valid, vote, fault}), 32'({1'b1, 1'b0, 4'h0, 3'b000}));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].pre_clr) begin
            @(negedge clk);
            clr_fault = 1'b1;
            @(negedge clk);
            clr_fault = 1'b0;
            chk($sformatf("v%0d_clr", i), 32'(fault), 32'd0);
         end
         run_word(vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].ev, vecs[i].ee,
                  vecs[i].ed, vecs[i].ef, $sformatf("v%0d", i));
      end

      // Asynchronous reset mid-cycle with faults latched and a result pending
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst", 32'({in_ready, out_valid, vote, out_err, disagree, fault}),
          32'({1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 3'b000}));
      @(negedge clk);
      rst = 1'b0;

      // Backpressure: result held stable, new input ignored
      out_ready = 1'b0;
      run_word(4'hC, 4'hC, 4'h4, 4'hC, 1'b0, 3'b100, 3'b000, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         ch1 = 4'h9; ch2 = 4'h6; ch3 = 4'h0;
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d", i), 32'({out_valid, in_ready, vote, disagree}),
             32'({1'b1, 1'b0, 4'hC, 3'b100}));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

      // Reset while in CAPTURE drops the transaction
      accept_word(4'hF, 4'h0, 4'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_capture", 32'({out_valid, in_ready}), 32'b01);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("no_pulse%0d", i), 32'(out_valid), 32'd0);
      end
      run_word(4'h5, 4'h5, 4'h5, 4'h5, 1'b0, 3'b000, 3'b000, "after_rst");

      // clr_fault on the edge where the fault would latch
      run_word(4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000, "race1");
      run_word(4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000, "race2");
      accept_word(4'hF, 4'h3, 4'h3);
      clr_fault = 1'b1;
      @(posedge clk);
      #1;
      clr_fault = 1'b0;
      chk("race3", 32'({out_valid, vote, disagree, fault}), 32'({1'b1, 4'h3, 3'b001, 3'b000}));
      // Counters were cleared too: three fresh mismatches are needed
      run_word(4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000, "race4");
      run_word(4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b000, "race5");
      run_word(4'hF, 4'h3, 4'h3, 4'h3, 1'b0, 3'b001, 3'b001, "race6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
